// File: rtl/fb_pkg.sv
// Shared constants, FSM encoding and address/bit helpers for the 320x200 1bpp framebuffer.
package fb_pkg;
    localparam int FB_W      = 320;
    localparam int FB_H      = 200;
    localparam int FB_STRIDE = 40;
    localparam int FB_WORDS  = 8000;
    localparam int FB_AW     = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WBACK = 2'd3
    } fb_state_t;

    // y*40 + x/8 built from shifts so no multiplier is needed
    function automatic logic [FB_AW-1:0] fb_word_addr(input logic [8:0] x, input logic [7:0] y);
        logic [FB_AW-1:0] w_y;
        w_y = {5'd0, y};
        return (w_y << 5) + (w_y << 3) + {7'd0, x[8:3]};
    endfunction

    function automatic logic [7:0] fb_set_bit(input logic [7:0] word, input logic [2:0] idx,
                                              input logic val);
        logic [7:0] w_word;
        w_word      = word;
        w_word[idx] = val;
        return w_word;
    endfunction
endpackage

// File: rtl/fb_ram.sv
// Single-port 8000x8 synchronous RAM, one-cycle read latency, read-first on write.
module fb_ram
    import fb_pkg::*;
(
    input  logic             clk,
    input  logic [FB_AW-1:0] addr,
    input  logic [7:0]       din,
    input  logic             we,
    output logic [7:0]       dout
);
    logic [7:0] r_mem [0:FB_WORDS-1];

    // Addresses past the last word are harmless: writes dropped, reads return zero.
    always_ff @(posedge clk) begin
        if (addr < 13'(FB_WORDS)) begin
            if (we) begin
                r_mem[addr] <= din;
            end
            dout <= r_mem[addr];
        end else begin
            dout <= 8'h00;
        end
    end
endmodule

// File: rtl/fb_mem.sv
// Framebuffer controller: pixel read-modify-write FSM plus priority scanout word reads.
module fb_mem
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [8:0]        x_b,
    input  logic [7:0]        y_b,
    input  logic              read_b,
    input  logic              write_b,
    input  logic              in_b,
    output logic              out_b,
    output logic              rdy_b,
    input  logic              scan_req,
    input  logic [FB_AW-1:0]  scan_addr,
    output logic [7:0]        scan_data,
    output logic              scan_valid
);
    fb_state_t        r_state;
    logic [FB_AW-1:0] r_addr;
    logic [2:0]       r_bit;
    logic             r_din;
    logic             r_is_wr;
    logic [7:0]       r_hold;

    logic [FB_AW-1:0] w_ram_addr;
    logic [7:0]       w_ram_din;
    logic             w_ram_we;
    logic [7:0]       w_ram_q;
    logic             w_in_range;

    assign w_in_range = (x_b < 9'(FB_W)) && (y_b < 8'(FB_H));
    assign scan_data  = w_ram_q;

    // Scanout owns the RAM port whenever it asks; the FSM stalls in ISSUE/WBACK meanwhile.
    always_comb begin
        w_ram_addr = r_addr;
        w_ram_din  = r_hold;
        w_ram_we   = 1'b0;
        if (scan_req) begin
            w_ram_addr = scan_addr;
        end else if (r_state == ST_WBACK) begin
            w_ram_we = 1'b1;
        end else begin
            w_ram_we = 1'b0;
        end
    end

    fb_ram u_ram (
        .clk  (clk),
        .addr (w_ram_addr),
        .din  (w_ram_din),
        .we   (w_ram_we),
        .dout (w_ram_q)
    );

    // Pixel request FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= 13'd0;
            r_bit      <= 3'd0;
            r_din      <= 1'b0;
            r_is_wr    <= 1'b0;
            r_hold     <= 8'h00;
            rdy_b      <= 1'b1;
            out_b      <= 1'b0;
            scan_valid <= 1'b0;
        end else begin
            scan_valid <= scan_req;
            case (r_state)
                ST_IDLE: begin
                    if (!rdy_b) begin
                        // completion cycle of an out-of-range request
                        rdy_b <= 1'b1;
                    end else if (write_b || read_b) begin
                        r_addr  <= fb_word_addr(x_b, y_b);
                        r_bit   <= x_b[2:0];
                        r_din   <= in_b;
                        r_is_wr <= write_b;
                        rdy_b   <= 1'b0;
                        if (w_in_range) begin
                            r_state <= ST_ISSUE;
                        end else if (!write_b) begin
                            out_b <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (!scan_req) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (r_is_wr) begin
                        r_hold  <= fb_set_bit(w_ram_q, r_bit, r_din);
                        r_state <= ST_WBACK;
                    end else begin
                        out_b   <= w_ram_q[r_bit];
                        rdy_b   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WBACK: begin
                    if (!scan_req) begin
                        rdy_b   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WBACK;
                    end
                end
                default: begin
                    rdy_b   <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_mem.sv
// Directed table-driven bench for fb_mem plus hand-written scan contention and reset sequences.
module tb_fb_mem;
    logic        clk;
    logic        rst_n;
    logic [8:0]  x_b;
    logic [7:0]  y_b;
    logic        read_b;
    logic        write_b;
    logic        in_b;
    logic        out_b;
    logic        rdy_b;
    logic        scan_req;
    logic [12:0] scan_addr;
    logic [7:0]  scan_data;
    logic        scan_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       wr;
        logic [8:0] x;
        logic [7:0] y;
        logic       v;
        int         edges;
        logic       exp_out;
    } vec_t;

    vec_t vecs[$];

    fb_mem dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x_b        (x_b),
        .y_b        (y_b),
        .read_b     (read_b),
        .write_b    (write_b),
        .in_b       (in_b),
        .out_b      (out_b),
        .rdy_b      (rdy_b),
        .scan_req   (scan_req),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .scan_valid (scan_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wr, input int x, input int y, input logic v,
                                input int edges, input logic exp_out);
        vec_t t;
        t.wr = wr; t.x = 9'(x); t.y = 8'(y); t.v = v; t.edges = edges; t.exp_out = exp_out;
        return t;
    endfunction

    task automatic pixel_op(input logic wr, input logic [8:0] x, input logic [7:0] y,
                            input logic v, output int edges);
        @(negedge clk);
        write_b = wr; read_b = !wr; x_b = x; y_b = y; in_b = v;
        @(posedge clk);
        @(negedge clk);
        write_b = 1'b0; read_b = 1'b0;
        x_b  = 9'($urandom_range(511));
        y_b  = 8'($urandom_range(255));
        in_b = 1'($urandom_range(1));
        chk("busy_after_capture", 32'(rdy_b), 32'd0);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!rdy_b && edges < 20);
    endtask

    task automatic scan_read(input logic [12:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        scan_req = 1'b1; scan_addr = a;
        @(posedge clk);
        @(negedge clk);
        scan_req = 1'b0;
        chk({name, "_valid"}, 32'(scan_valid), 32'd1);
        chk(name, 32'(scan_data), 32'(exp));
    endtask

    initial begin
        int e;
        logic [7:0] pat;
        rst_n = 1'b0; x_b = 9'd0; y_b = 8'd0; read_b = 1'b0; write_b = 1'b0;
        in_b = 1'b0; scan_req = 1'b0; scan_addr = 13'd0;

        // word 81: x=8..15 on y=2, only x=13 set -> 8'h20
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1'b1, 8 + i, 2, (i == 5), 3, 1'b0));
        vecs.push_back(mk(1'b0, 13, 2, 1'b0, 2, 1'b1));
        vecs.push_back(mk(1'b0, 12, 2, 1'b0, 2, 1'b0));
        vecs.push_back(mk(1'b1, 8, 199, 1'b0, 3, 1'b0));
        pat = 8'h8D;
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1'b1, i, 199, pat[i], 3, 1'b0));
        vecs.push_back(mk(1'b0, 8, 199, 1'b0, 2, 1'b0));
        vecs.push_back(mk(1'b0, 0, 199, 1'b0, 2, 1'b1));
        vecs.push_back(mk(1'b0, 7, 199, 1'b0, 2, 1'b1));
        vecs.push_back(mk(1'b0, 1, 199, 1'b0, 2, 1'b0));
        vecs.push_back(mk(1'b1, 0, 1, 1'b0, 3, 1'b0));
        vecs.push_back(mk(1'b1, 320, 0, 1'b1, 1, 1'b0));
        vecs.push_back(mk(1'b0, 0, 1, 1'b0, 2, 1'b0));
        vecs.push_back(mk(1'b1, 0, 200, 1'b1, 1, 1'b0));
        vecs.push_back(mk(1'b0, 13, 2, 1'b0, 2, 1'b1));
        vecs.push_back(mk(1'b0, 320, 0, 1'b0, 1, 1'b0));
        vecs.push_back(mk(1'b0, 13, 2, 1'b0, 2, 1'b1));
        vecs.push_back(mk(1'b0, 0, 200, 1'b0, 1, 1'b0));

        repeat (2) @(negedge clk);
        chk("reset_rdy", 32'(rdy_b), 32'd1);
        chk("reset_out", 32'(out_b), 32'd0);
        chk("reset_scan_valid", 32'(scan_valid), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            pixel_op(vecs[i].wr, vecs[i].x, vecs[i].y, vecs[i].v, e);
            chk($sformatf("vec%0d_edges", i), 32'(e), 32'(vecs[i].edges));
            if (!vecs[i].wr) chk($sformatf("vec%0d_out", i), 32'(out_b), 32'(vecs[i].exp_out));
        end

        scan_read(13'd81, 8'h20, "scan81");
        scan_read(13'd7960, 8'h8D, "scan7960");

        // write x=9,y=2 with scan_req held for 4 cycles while in ISSUE
        @(negedge clk);
        write_b = 1'b1; x_b = 9'd9; y_b = 8'd2; in_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        write_b = 1'b0; scan_req = 1'b1; scan_addr = 13'd7960;
        e = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            chk("cont_scan_valid", 32'(scan_valid), 32'd1);
            chk("cont_scan_data", 32'(scan_data), 32'h8D);
            chk("cont_busy", 32'(rdy_b), 32'd0);
            if (k == 3) scan_req = 1'b0;
        end
        @(posedge clk);
        e++;
        @(negedge clk);
        chk("cont_scan_valid_drop", 32'(scan_valid), 32'd0);
        while (!rdy_b && e < 30) begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        chk("cont_edges", 32'(e), 32'd7);
        scan_read(13'd81, 8'h22, "cont_final");

        // scan of the same word while in WBACK sees the pre-write value
        @(negedge clk);
        write_b = 1'b1; x_b = 9'd10; y_b = 8'd2; in_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        write_b = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        scan_req = 1'b1; scan_addr = 13'd81;
        @(posedge clk);
        @(negedge clk);
        scan_req = 1'b0;
        chk("wback_scan_valid", 32'(scan_valid), 32'd1);
        chk("wback_scan_old", 32'(scan_data), 32'h22);
        chk("wback_stalled", 32'(rdy_b), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("wback_done", 32'(rdy_b), 32'd1);
        scan_read(13'd81, 8'h26, "wback_scan_new");

        // reset asserted in WBACK of a write: aborted, word unchanged
        pixel_op(1'b0, 9'd13, 8'd2, 1'b0, e);
        chk("pre_reset_out", 32'(out_b), 32'd1);
        @(negedge clk);
        write_b = 1'b1; x_b = 9'd11; y_b = 8'd2; in_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        write_b = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", 32'(rdy_b), 32'd1);
        chk("midrst_out", 32'(out_b), 32'd0);
        chk("midrst_scan_valid", 32'(scan_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        scan_read(13'd81, 8'h26, "post_reset_word");
        pixel_op(1'b0, 9'd11, 8'd2, 1'b0, e);
        chk("post_reset_edges", 32'(e), 32'd2);
        chk("post_reset_pixel", 32'(out_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
